rib_ex_bridge: RTL
==================

// Module: rib_ex_bridge
// PURPOSE
//  Registered bridge between the core's data-side RIB master port (addr/data/req/we/ack) and the
//  RIB interconnect. Captures one load/store per transaction, presents it to the bus until the
//  slave acks, then returns a one-cycle ack plus read data to the core.
//  While a transaction is outstanding it drives the core's bus hold flag, stalling the pipeline.
// PARAMETERS
//  ADDR_W          32            address width
//  DATA_W          32            data width
//  TIMEOUT_CYCLES  255           max cycles in REQ before abort (used only with timeout macro)
//  ERR_RDATA       32'hDEADBEEF  read data returned on a timed-out read
// PORTS
//  clk          in   1       clock
//  rst          in   1       reset, asynchronous, active-low
//  core_addr_i  in   ADDR_W  core access address
//  core_wdata_i in   DATA_W  core store data
//  core_req_i   in   1       core access request (level)
//  core_we_i    in   1       1 = store, 0 = load
//  core_rdata_o out  DATA_W  load data, valid while core_ack_o=1
//  core_ack_o   out  1       one-cycle completion pulse to core
//  hold_flag_o  out  1       pipeline hold to core (rib hold input)
//  m_addr_o     out  ADDR_W  bus address (registered)
//  m_data_o     out  DATA_W  bus write data (registered)
//  m_req_o      out  1       bus request
//  m_we_o       out  1       bus write enable
//  m_data_i     in   DATA_W  bus read data, valid with m_ack_i
//  m_ack_i      in   1       bus slave ack
//  err_o        out  1       one-cycle pulse on timeout abort
//  err_addr_o   out  ADDR_W  address of last aborted access (sticky until next abort/reset)
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; all outputs and capture regs 0; m_req_o drops at once, even
//    mid-transaction; the aborted access is not acked.
//  - FSM IDLE -> REQ -> RESP -> IDLE.
//  - IDLE: if core_req_i=1, latch addr/wdata/we into m_* regs and go to REQ.
//  - REQ: m_req_o=1, m_* stable. If m_ack_i=1, latch m_data_i (0 for stores) and go to RESP.
//  - RESP: core_ack_o=1 for exactly one cycle; core_rdata_o = latched data; then go to IDLE.
//    Outside RESP, core_rdata_o and core_ack_o are 0.
//  - hold_flag_o = (state==REQ) | (state==IDLE & core_req_i). This is combinational, so the core
//    stalls in the same cycle it raises req. hold_flag_o is 0 in RESP.
//  - The core drops core_req_i in the core_ack_o cycle. core_req_i=1 seen in IDLE is always a new
//    access; back-to-back accesses cost 3 cycles each minimum.
//  - Latency: req seen in cycle 0; m_req_o in cycle 1; ack in cycle k>=1 gives core_ack_o in k+1.
//  - m_ack_i is ignored outside REQ. Core inputs are ignored outside IDLE; no second capture.
//  - m_req_o is registered: it rises the cycle after IDLE capture and falls on entry to RESP.
// CONFIGURATION
//  RIB_BRIDGE_TIMEOUT_EN defined:
//  - Counter of width $clog2(TIMEOUT_CYCLES+1): cleared on entry to REQ, +1 per REQ cycle.
//  - On count==TIMEOUT_CYCLES with m_ack_i=0: go to RESP, latch ERR_RDATA (0 for stores),
//    err_o=1 for one cycle, err_addr_o<=m_addr_o.
//  - Ack and timeout in the same cycle: ack wins, normal completion, no err_o.
//  RIB_BRIDGE_TIMEOUT_EN undefined:
//  - REQ waits indefinitely; no counter logic; err_o and err_addr_o tied to 0.
// TESTING
//  1. Load addr=0x1000_0004, slave acks 1 cycle after m_req_o -> core_ack_o at cycle 3,
//     rdata=slave data, hold 1 on cycles 0-2.
//  2. Store addr=0x2000_0000 wdata=0xA5A5_5A5A, ack after 5 wait cycles -> m_we_o=1 and
//     m_data_o stable all REQ cycles; single ack; core_rdata_o=0.
//  3. Two back-to-back loads -> two separate m_req_o bursts, two ack pulses, no duplicate issue.
//  4. rst low during REQ -> m_req_o=0 immediately; no core_ack_o; restart works after release.
//  5. TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> err_o and core_ack_o in sequence,
//     rdata=0xDEADBEEF, err_addr_o=addr.
//  6. TIMEOUT_EN, ack on the timeout cycle -> normal data returned, err_o stays 0.

Source files
------------

// File: rtl/rib_ex_bridge.sv
// Registered bridge between the core's data-side RIB master port and the RIB interconnect.
// Optional REQ-phase timeout abort is enabled by defining RIB_BRIDGE_TIMEOUT_EN.
module rib_ex_bridge #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  output logic [DATA_W-1:0] core_rdata_o,
  output logic              core_ack_o,
  output logic              hold_flag_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_req_o,
  output logic              m_we_o,
  input  logic [DATA_W-1:0] m_data_i,
  input  logic              m_ack_i,
  output logic              err_o,
  output logic [ADDR_W-1:0] err_addr_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic                capture_s;
  logic                ack_take_s;
  logic                timeout_s;
  logic                timeout_hit_s;
  logic [ADDR_W-1:0]   m_addr_r;
  logic [DATA_W-1:0]   m_data_r;
  logic                m_we_r;
  logic                m_req_r;
  logic                core_ack_r;
  logic [DATA_W-1:0]   core_rdata_r;
  logic [DATA_W-1:0]   err_rdata_s;

  // Stores never return data, even on an aborted access.
  assign err_rdata_s = m_we_r ? {DATA_W{1'b0}} : ERR_RDATA;

`ifdef RIB_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0]  cnt_r;
  logic              err_r;
  logic [ADDR_W-1:0] err_addr_r;

  assign timeout_hit_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES));

  // REQ-phase cycle counter plus sticky abort address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r      <= {CNT_W{1'b0}};
      err_r      <= 1'b0;
      err_addr_r <= {ADDR_W{1'b0}};
    end else begin
      if (capture_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == ST_REQ) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      err_r <= timeout_s;
      if (timeout_s) begin
        err_addr_r <= m_addr_r;
      end else begin
        err_addr_r <= err_addr_r;
      end
    end
  end

  assign err_o      = err_r;
  assign err_addr_o = err_addr_r;
`else
  assign timeout_hit_s = 1'b0;
  assign err_o         = 1'b0;
  assign err_addr_o    = {ADDR_W{1'b0}};
`endif

  // Next-state logic; an ack in the timeout cycle takes priority over the abort.
  always_comb begin
    state_s    = state_r;
    capture_s  = 1'b0;
    ack_take_s = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (core_req_i) begin
          state_s   = ST_REQ;
          capture_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (m_ack_i) begin
          state_s    = ST_RESP;
          ack_take_s = 1'b1;
        end else if (timeout_hit_s) begin
          state_s   = ST_RESP;
          timeout_s = 1'b1;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, bus-side capture registers and core-side response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      m_addr_r     <= {ADDR_W{1'b0}};
      m_data_r     <= {DATA_W{1'b0}};
      m_we_r       <= 1'b0;
      m_req_r      <= 1'b0;
      core_ack_r   <= 1'b0;
      core_rdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_s;
      if (capture_s) begin
        m_addr_r <= core_addr_i;
        m_data_r <= core_wdata_i;
        m_we_r   <= core_we_i;
      end else begin
        m_addr_r <= m_addr_r;
        m_data_r <= m_data_r;
        m_we_r   <= m_we_r;
      end
      m_req_r    <= (state_s == ST_REQ);
      core_ack_r <= (state_s == ST_RESP);
      if (ack_take_s) begin
        core_rdata_r <= m_we_r ? {DATA_W{1'b0}} : m_data_i;
      end else if (timeout_s) begin
        core_rdata_r <= err_rdata_s;
      end else begin
        core_rdata_r <= {DATA_W{1'b0}};
      end
    end
  end

  // The core must stall in the very cycle it raises req, hence the IDLE term.
  assign hold_flag_o  = (state_r == ST_REQ) | ((state_r == ST_IDLE) & core_req_i);
  assign m_addr_o     = m_addr_r;
  assign m_data_o     = m_data_r;
  assign m_we_o       = m_we_r;
  assign m_req_o      = m_req_r;
  assign core_ack_o   = core_ack_r;
  assign core_rdata_o = core_rdata_r;

endmodule
